// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: default widths, opcode constants,
// loader FSM encoding and small helpers used by alu_input_loader.
package alu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned OP_WIDTH_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_WAIT_OP = 2'd2,
    S_READY   = 2'd3
  } state_e;

  // Request bits are {op, b, a}; A wins over B, B wins over OP.
  function automatic logic [2:0] pick_first(input logic [2:0] req);
    logic [2:0] grant;
    grant = 3'b000;
    if (req[0]) begin
      grant = 3'b001;
    end else if (req[1]) begin
      grant = 3'b010;
    end else if (req[2]) begin
      grant = 3'b100;
    end
    return grant;
  endfunction

  function automatic state_e advance(input state_e s);
    state_e n;
    unique case (s)
      S_WAIT_A:  n = S_WAIT_B;
      S_WAIT_B:  n = S_WAIT_OP;
      S_WAIT_OP: n = S_READY;
      S_READY:   n = S_READY;
      default:   n = S_WAIT_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton front end: 2-flop synchronizer, optional debouncer (ALU_LOADER_DEBOUNCE_EN)
// and rising-edge detector producing a single-cycle press pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  // Not reset: the chain keeps tracking the pin so a button held through
  // reset is seen at its true level the moment reset drops.
  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            stable_q;
  logic            stable_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short glitches never get through.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Accepted level starts high so a held button must be seen released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  // prev starts high: no pulse until the level has been observed low.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads ALU operands A, B and opcode from a switch bank using three pushbuttons.
// Optional button debounce is compiled in with macro ALU_LOADER_DEBOUNCE_EN.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned OP_WIDTH        = OP_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_sw,
  input  logic                  i_btn_a,
  input  logic                  i_btn_b,
  input  logic                  i_btn_op,
  output logic [DATA_WIDTH-1:0] o_A,
  output logic [DATA_WIDTH-1:0] o_B,
  output logic [OP_WIDTH-1:0]   o_Op,
  output logic                  o_valid,
  output logic [2:0]            o_loaded
);

  if (OP_WIDTH > DATA_WIDTH) begin : g_bad_width
    $error("OP_WIDTH must not exceed DATA_WIDTH");
  end

  logic pulse_a;
  logic pulse_b;
  logic pulse_op;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_a (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_a),
    .pulse_o(pulse_a)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_b (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_b),
    .pulse_o(pulse_b)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_op (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_op),
    .pulse_o(pulse_op)
  );

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] b_d;
  logic [OP_WIDTH-1:0]   op_q;
  logic [OP_WIDTH-1:0]   op_d;
  logic [2:0]            loaded_q;
  logic [2:0]            loaded_d;
  logic                  valid_q;
  logic                  valid_d;
  logic [2:0]            req;
  logic [2:0]            grant;

  always_comb begin
    req      = 3'b000;
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    loaded_d = loaded_q;

    // While loading, only the awaited button is listened to.
    unique case (state_q)
      S_WAIT_A:  req = {2'b00, pulse_a};
      S_WAIT_B:  req = {1'b0, pulse_b, 1'b0};
      S_WAIT_OP: req = {pulse_op, 2'b00};
      S_READY:   req = {pulse_op, pulse_b, pulse_a};
      default:   req = 3'b000;
    endcase

    grant = pick_first(req);

    if (grant[0]) begin
      a_d         = i_sw;
      loaded_d[0] = 1'b1;
    end
    if (grant[1]) begin
      b_d         = i_sw;
      loaded_d[1] = 1'b1;
    end
    if (grant[2]) begin
      op_d        = i_sw[OP_WIDTH-1:0];
      loaded_d[2] = 1'b1;
    end
    if (grant != 3'b000) begin
      state_d = advance(state_q);
    end

    valid_d = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      loaded_q <= 3'b000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
    end
  end

  assign o_A      = a_q;
  assign o_B      = b_q;
  assign o_Op     = op_q;
  assign o_valid  = valid_q;
  assign o_loaded = loaded_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Self-checking bench for alu_input_loader: directed vector table, reset/hold
// sequences and randomized presses checked against a behavioural model.
module tb_alu_input_loader;
  import alu_pkg::*;

  localparam int unsigned Deb = 16;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int unsigned Lat = 3 + Deb;
`else
  localparam int unsigned Lat = 3;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] i_sw;
  logic       i_btn_a;
  logic       i_btn_b;
  logic       i_btn_op;
  logic [7:0] o_A;
  logic [7:0] o_B;
  logic [5:0] o_Op;
  logic       o_valid;
  logic [2:0] o_loaded;

  alu_input_loader #(
    .DATA_WIDTH     (8),
    .OP_WIDTH       (6),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_sw    (i_sw),
    .i_btn_a (i_btn_a),
    .i_btn_b (i_btn_b),
    .i_btn_op(i_btn_op),
    .o_A     (o_A),
    .o_B     (o_B),
    .o_Op    (o_Op),
    .o_valid (o_valid),
    .o_loaded(o_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Packed view {A, B, Op, valid, loaded}
  function automatic logic [25:0] mk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op, input logic v, input logic [2:0] l);
    return {a, b, op, v, l};
  endfunction

  function automatic logic [25:0] outs();
    return {o_A, o_B, o_Op, o_valid, o_loaded};
  endfunction

  task automatic check(input string nm, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got A=%h B=%h Op=%b valid=%b loaded=%b, want A=%h B=%h Op=%b valid=%b loaded=%b",
               nm, act[25:18], act[17:10], act[9:4], act[3], act[2:0],
               exp[25:18], exp[17:10], exp[9:4], exp[3], exp[2:0]);
    end
  endtask

  // Behavioural model: how many registers have been loaded in order, plus values.
  int         m_stage;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [5:0] m_op;
  logic [2:0] m_ld;

  function automatic logic [25:0] model_outs();
    return mk(m_a, m_b, m_op, (m_stage == 3), m_ld);
  endfunction

  task automatic model_reset();
    m_stage = 0; m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_ld = 3'b000;
  endtask

  task automatic model_press(input logic pa, input logic pb, input logic pop,
                             input logic [7:0] sw);
    bit take_a, take_b, take_op;
    take_a  = pa  && (m_stage == 0 || m_stage == 3);
    take_b  = pb  && (m_stage == 1 || m_stage == 3);
    take_op = pop && (m_stage == 2 || m_stage == 3);
    if (take_a) begin
      m_a = sw; m_ld[0] = 1'b1;
    end else if (take_b) begin
      m_b = sw; m_ld[1] = 1'b1;
    end else if (take_op) begin
      m_op = sw[5:0]; m_ld[2] = 1'b1;
    end
    if ((take_a || take_b || take_op) && m_stage < 3) m_stage++;
  endtask

  logic [25:0] cur_exp;

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (Deb + 6) @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge. Buttons rise now; capture lands on the Lat-th edge.
  task automatic press(input string nm, input logic pa, input logic pb, input logic pop,
                       input logic [7:0] sw, input logic [25:0] exp);
    i_sw = sw; i_btn_a = pa; i_btn_b = pb; i_btn_op = pop;
    repeat (Lat - 1) @(posedge clk);
    #1 check({nm, "_pre"}, outs(), cur_exp);
    @(posedge clk);
    #1 check(nm, outs(), exp);
    cur_exp = exp;
    repeat (3) @(posedge clk);
    #1 i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
    repeat (Lat + 3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        pa;
    logic        pb;
    logic        pop;
    logic [7:0]  sw;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic pa, pb, pop;
    logic [7:0] sw;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h33, mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000)};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h3F, mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000)};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h05, mk(8'h05, 8'h00, 6'h00, 1'b0, 3'b001)};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, mk(8'h05, 8'h00, 6'h00, 1'b0, 3'b001)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h0A, mk(8'h05, 8'h0A, 6'h00, 1'b0, 3'b011)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h20, mk(8'h05, 8'h0A, OP_ADD, 1'b1, 3'b111)};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h7F, mk(8'h7F, 8'h0A, OP_ADD, 1'b1, 3'b111)};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h12, mk(8'h7F, 8'h12, OP_ADD, 1'b1, 3'b111)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h26, mk(8'h7F, 8'h12, OP_XOR, 1'b1, 3'b111)};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h99, mk(8'h99, 8'h12, OP_XOR, 1'b1, 3'b111)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hFF, mk(8'h99, 8'h12, 6'h3F, 1'b1, 3'b111)};

    i_sw = 8'h00; i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
    @(posedge clk);
    #1 do_reset();
    cur_exp = mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000);
    check("reset_state", outs(), cur_exp);

    for (int i = 0; i < 11; i++) begin
      press($sformatf("vec%0d", i), vecs[i].pa, vecs[i].pb, vecs[i].pop, vecs[i].sw,
            vecs[i].exp);
    end

    // Long hold: one capture only, later switch changes ignored.
    i_sw = 8'h11; i_btn_a = 1'b1;
    repeat (Lat + 2) @(posedge clk);
    #1 i_sw = 8'h22;
    repeat (48 - Lat) @(posedge clk);
    #1 check("hold_single_capture", outs(), mk(8'h11, 8'h12, 6'h3F, 1'b1, 3'b111));
    i_btn_a = 1'b0;
    repeat (Lat + 3) @(posedge clk);
    #1 check("hold_after_release", outs(), mk(8'h11, 8'h12, 6'h3F, 1'b1, 3'b111));

    // Reset in S_WAIT_OP with buttons held across reset release.
    do_reset();
    cur_exp = mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000);
    press("rs_a", 1'b1, 1'b0, 1'b0, 8'hA1, mk(8'hA1, 8'h00, 6'h00, 1'b0, 3'b001));
    press("rs_b", 1'b0, 1'b1, 1'b0, 8'hB2, mk(8'hA1, 8'hB2, 6'h00, 1'b0, 3'b011));
    i_sw = 8'h5A; i_btn_b = 1'b1; i_btn_a = 1'b1;
    @(posedge clk);
    #1 do_reset();
    repeat (10) @(posedge clk);
    #1 check("held_across_reset", outs(), mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000));
    i_btn_a = 1'b0; i_btn_b = 1'b0;
    repeat (Lat + 3) @(posedge clk);
    #1 cur_exp = mk(8'h00, 8'h00, 6'h00, 1'b0, 3'b000);
    check("released_no_capture", outs(), cur_exp);
    press("repress_a", 1'b1, 1'b0, 1'b0, 8'h5A, mk(8'h5A, 8'h00, 6'h00, 1'b0, 3'b001));

`ifdef ALU_LOADER_DEBOUNCE_EN
    // Short glitch must never reach the edge detector.
    i_sw = 8'hC3; i_btn_b = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_btn_b = 1'b0;
    repeat (Lat + 5) @(posedge clk);
    #1 check("glitch_rejected", outs(), cur_exp);
`endif

    // Randomized presses against the model, starting from a clean reset.
    do_reset();
    model_reset();
    cur_exp = model_outs();
    check("rand_reset", outs(), cur_exp);
    for (int i = 0; i < 30; i++) begin
      pa  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      pop = 1'($urandom_range(0, 1));
      if (!pa && !pb && !pop) pb = 1'b1;
      sw = 8'($urandom);
      model_press(pa, pb, pop, sw);
      press($sformatf("rand%0d", i), pa, pb, pop, sw, model_outs());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
